// File: rtl/rv32i_branch_predict_unit_pkg.sv
// Shared definitions for the branch unit: comparison op codes, the BHT
// counter type, its weakly-not-taken reset value and index-width helper.
package rv32i_branch_predict_unit_pkg;

    // Comparison selects, as produced by the decoder
    localparam int ALU_OP_WIDTH = 4;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_EQ  = 4'd8;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_NEQ = 4'd9;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_LT  = 4'd10;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_GE  = 4'd11;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_LTU = 4'd12;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_GEU = 4'd13;

    // Default BHT counter: 2-bit, reset to weakly-not-taken (01)
    localparam int BHT_CNT_WIDTH = 2;
    typedef logic [BHT_CNT_WIDTH-1:0] bht_cnt_t;
    localparam bht_cnt_t BHT_INIT = bht_cnt_t'((1 << (BHT_CNT_WIDTH - 1)) - 1);

    // Weakly-not-taken value for an arbitrary counter width (MSB clear, rest set)
    function automatic int bht_init_value(input int cnt_width);
        return (1 << (cnt_width - 1)) - 1;
    endfunction

    // Number of PC bits used to index a BHT of the given depth
    function automatic int bht_idx_width(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/rv32i_sat_counter.sv
// Next-value function of a saturating up/down counter of CNT_WIDTH bits.
module rv32i_sat_counter #(
    parameter int CNT_WIDTH = 2
) (
    input  logic [CNT_WIDTH-1:0] cnt,
    input  logic                 inc,
    output logic [CNT_WIDTH-1:0] next
);

    // Step toward taken or not-taken, holding at the rails
    always_comb begin
        next = cnt;
        if (inc) begin
            if (cnt != {CNT_WIDTH{1'b1}}) next = cnt + CNT_WIDTH'(1);
        end else begin
            if (cnt != {CNT_WIDTH{1'b0}}) next = cnt - CNT_WIDTH'(1);
        end
    end

endmodule

// File: rtl/rv32i_branch_predict_unit.sv
// Branch unit: resolves branches/jumps in EX, predicts direction for IF from
// a BHT of saturating counters, issues a registered redirect on mispredict.
module rv32i_branch_predict_unit
    import rv32i_branch_predict_unit_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int BHT_DEPTH  = 64,
    parameter int CNT_WIDTH  = BHT_CNT_WIDTH,
    parameter int PERF_WIDTH = 32
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic [WIDTH-1:0]        i_if_pc,
    output logic                    o_if_pred_taken,
    input  logic                    i_ex_valid,
    input  logic                    i_ex_stall,
    input  logic [WIDTH-1:0]        i_ex_pc,
    input  logic                    i_ex_pred_taken,
    input  logic [ALU_OP_WIDTH-1:0] i_branch_op,
    input  logic [WIDTH-1:0]        i_rs1_data,
    input  logic [WIDTH-1:0]        i_rs2_data,
    input  logic                    i_do_branch,
    input  logic                    i_do_jump,
    input  logic [WIDTH-1:0]        i_target,
    output logic                    o_redirect,
    output logic [WIDTH-1:0]        o_redirect_pc,
    output logic [PERF_WIDTH-1:0]   o_perf_branches,
    output logic [PERF_WIDTH-1:0]   o_perf_mispredicts
);

    localparam int IDX_W = bht_idx_width(BHT_DEPTH);
    localparam logic [CNT_WIDTH-1:0] INIT_VAL = (CNT_WIDTH == BHT_CNT_WIDTH)
        ? CNT_WIDTH'(BHT_INIT) : CNT_WIDTH'(bht_init_value(CNT_WIDTH));

    logic [CNT_WIDTH-1:0] bht [BHT_DEPTH];
    logic [IDX_W-1:0]     if_idx;
    logic [IDX_W-1:0]     ex_idx;
    logic                 cond;
    logic                 resolve;
    logic                 actual;
    logic                 mispredict;
    logic                 bht_update;
    logic [CNT_WIDTH-1:0] bht_next;
    logic                 unused_pc_bits;

    assign if_idx = i_if_pc[IDX_W+1:2];
    assign ex_idx = i_ex_pc[IDX_W+1:2];
    assign unused_pc_bits = ^{i_if_pc, i_ex_pc};

    assign o_if_pred_taken = bht[if_idx][CNT_WIDTH-1];

    // Evaluate the branch condition selected by the decoder
    always_comb begin
        cond = 1'b0;
        case (i_branch_op)
            ALU_EQ:  cond = (i_rs1_data == i_rs2_data);
            ALU_NEQ: cond = (i_rs1_data != i_rs2_data);
            ALU_LT:  cond = ($signed(i_rs1_data) <  $signed(i_rs2_data));
            ALU_GE:  cond = ($signed(i_rs1_data) >= $signed(i_rs2_data));
            ALU_LTU: cond = (i_rs1_data <  i_rs2_data);
            ALU_GEU: cond = (i_rs1_data >= i_rs2_data);
            default: cond = 1'b0;
        endcase
    end

    assign resolve    = i_ex_valid & ~i_ex_stall & (i_do_branch | i_do_jump);
    assign actual     = i_do_jump | (i_do_branch & cond);
    assign mispredict = resolve & (actual != i_ex_pred_taken);
    assign bht_update = resolve & i_do_branch & ~i_do_jump;

    rv32i_sat_counter #(
        .CNT_WIDTH(CNT_WIDTH)
    ) u_sat_counter (
        .cnt  (bht[ex_idx]),
        .inc  (actual),
        .next (bht_next)
    );

    // Train the indexed BHT entry with each resolved conditional branch
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < BHT_DEPTH; i++) bht[i] <= INIT_VAL;
        end else if (bht_update) begin
            bht[ex_idx] <= bht_next;
        end
    end

    // Register the redirect pulse/target and count branches and mispredicts
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_redirect         <= 1'b0;
            o_redirect_pc      <= '0;
            o_perf_branches    <= '0;
            o_perf_mispredicts <= '0;
        end else begin
            o_redirect <= mispredict;
            if (mispredict) begin
                o_redirect_pc      <= actual ? i_target : (i_ex_pc + WIDTH'(4));
                o_perf_mispredicts <= o_perf_mispredicts + PERF_WIDTH'(1);
            end
            if (bht_update) o_perf_branches <= o_perf_branches + PERF_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_rv32i_branch_predict_unit.sv
// Scoreboard bench for rv32i_branch_predict_unit: directed scenarios followed
// by randomized traffic, checked against a behavioural model of the BHT.
module tb_rv32i_branch_predict_unit;
    import rv32i_branch_predict_unit_pkg::*;

    typedef struct {
        logic        rst;
        logic [31:0] if_pc;
        logic        valid;
        logic        stall;
        logic [31:0] ex_pc;
        logic        pred;
        logic [3:0]  op;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic        br;
        logic        jmp;
        logic [31:0] target;
    } stim_t;

    typedef struct {
        logic        red;
        logic [31:0] pc;
        logic [31:0] pbr;
        logic [31:0] pmis;
    } exp_t;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic [31:0] i_if_pc = '0;
    logic        o_if_pred_taken;
    logic        i_ex_valid = 1'b0;
    logic        i_ex_stall = 1'b0;
    logic [31:0] i_ex_pc = '0;
    logic        i_ex_pred_taken = 1'b0;
    logic [3:0]  i_branch_op = '0;
    logic [31:0] i_rs1_data = '0;
    logic [31:0] i_rs2_data = '0;
    logic        i_do_branch = 1'b0;
    logic        i_do_jump = 1'b0;
    logic [31:0] i_target = '0;
    logic        o_redirect;
    logic [31:0] o_redirect_pc;
    logic [31:0] o_perf_branches;
    logic [31:0] o_perf_mispredicts;

    int checks = 0;
    int failures = 0;
    exp_t exp_q[$];

    int          bht_m [64];
    logic [31:0] red_pc_m;
    logic [31:0] perf_br_m;
    logic [31:0] perf_mis_m;

    rv32i_branch_predict_unit dut (
        .i_clk              (i_clk),
        .i_rst_n            (i_rst_n),
        .i_if_pc            (i_if_pc),
        .o_if_pred_taken    (o_if_pred_taken),
        .i_ex_valid         (i_ex_valid),
        .i_ex_stall         (i_ex_stall),
        .i_ex_pc            (i_ex_pc),
        .i_ex_pred_taken    (i_ex_pred_taken),
        .i_branch_op        (i_branch_op),
        .i_rs1_data         (i_rs1_data),
        .i_rs2_data         (i_rs2_data),
        .i_do_branch        (i_do_branch),
        .i_do_jump          (i_do_jump),
        .i_target           (i_target),
        .o_redirect         (o_redirect),
        .o_redirect_pc      (o_redirect_pc),
        .o_perf_branches    (o_perf_branches),
        .o_perf_mispredicts (o_perf_mispredicts)
    );

    always #5 i_clk = ~i_clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void modelReset();
        for (int i = 0; i < 64; i++) bht_m[i] = 1;
        red_pc_m   = '0;
        perf_br_m  = '0;
        perf_mis_m = '0;
    endfunction

    function automatic int slot(input logic [31:0] pc);
        return int'((pc >> 2) % 64);
    endfunction

    function automatic logic branchTaken(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        int signed sa = a;
        int signed sb = b;
        case (op)
            ALU_EQ:  return a == b;
            ALU_NEQ: return a != b;
            ALU_LT:  return sa < sb;
            ALU_GE:  return sa >= sb;
            ALU_LTU: return a < b;
            ALU_GEU: return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    function automatic stim_t idle(input logic [31:0] if_pc);
        stim_t s;
        s = '{rst: 1'b0, if_pc: if_pc, valid: 1'b0, stall: 1'b0, ex_pc: '0, pred: 1'b0,
              op: '0, rs1: '0, rs2: '0, br: 1'b0, jmp: 1'b0, target: '0};
        return s;
    endfunction

    function automatic stim_t branch(input logic [31:0] pc, input logic [3:0] op,
                                     input logic [31:0] rs1, input logic [31:0] rs2,
                                     input logic pred, input logic [31:0] target);
        stim_t s;
        s = idle(pc);
        s.valid = 1'b1; s.ex_pc = pc; s.op = op; s.rs1 = rs1; s.rs2 = rs2;
        s.pred = pred; s.br = 1'b1; s.target = target;
        return s;
    endfunction

    // Drive one cycle of stimulus, check the prediction, and queue the expected response
    task automatic applyStimulus(input stim_t s);
        logic resolve;
        logic actual;
        logic mis;
        int   k;
        exp_t e;
        @(negedge i_clk);
        i_rst_n = ~s.rst;
        i_if_pc = s.if_pc; i_ex_valid = s.valid; i_ex_stall = s.stall; i_ex_pc = s.ex_pc;
        i_ex_pred_taken = s.pred; i_branch_op = s.op; i_rs1_data = s.rs1; i_rs2_data = s.rs2;
        i_do_branch = s.br; i_do_jump = s.jmp; i_target = s.target;
        if (s.rst) modelReset();
        #1;
        checkOutput("pred_taken", {31'b0, o_if_pred_taken}, {31'b0, bht_m[slot(s.if_pc)] >= 2});
        if (s.rst) begin
            checkOutput("reset_redirect", {31'b0, o_redirect}, 32'd0);
            checkOutput("reset_mispredicts", o_perf_mispredicts, 32'd0);
            e = '{red: 1'b0, pc: '0, pbr: '0, pmis: '0};
            exp_q.push_back(e);
            return;
        end
        resolve = s.valid && !s.stall && (s.br || s.jmp);
        actual  = s.jmp || (s.br && branchTaken(s.op, s.rs1, s.rs2));
        mis     = resolve && (actual != s.pred);
        if (mis) begin
            red_pc_m = actual ? s.target : s.ex_pc + 32'd4;
            perf_mis_m++;
        end
        if (resolve && s.br && !s.jmp) begin
            k = slot(s.ex_pc);
            if (actual) bht_m[k] = (bht_m[k] == 3) ? 3 : bht_m[k] + 1;
            else        bht_m[k] = (bht_m[k] == 0) ? 0 : bht_m[k] - 1;
            perf_br_m++;
        end
        e = '{red: mis, pc: red_pc_m, pbr: perf_br_m, pmis: perf_mis_m};
        exp_q.push_back(e);
    endtask

    // Monitor: after each active edge, compare registered outputs with the oldest expectation
    initial begin
        exp_t e;
        forever begin
            @(posedge i_clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checkOutput("redirect", {31'b0, o_redirect}, {31'b0, e.red});
                checkOutput("redirect_pc", o_redirect_pc, e.pc);
                checkOutput("perf_branches", o_perf_branches, e.pbr);
                checkOutput("perf_mispredicts", o_perf_mispredicts, e.pmis);
            end
        end
    end

    // Hard time limit so the run always ends
    initial begin
        #200000;
        $display("[TB] FAIL timeout actual=running required=finished");
        $fatal(1, "[TB] timeout");
    end

    // Directed scenarios, randomized traffic, reset mid-operation, summary
    initial begin
        stim_t s;
        logic [3:0] ops [8];
        int kind;
        ops = '{ALU_EQ, ALU_NEQ, ALU_LT, ALU_GE, ALU_LTU, ALU_GEU, 4'd0, 4'd3};
        modelReset();

        applyStimulus(idle(32'h100));
        applyStimulus(idle(32'h2A4));

        // BEQ taken, predicted not-taken
        applyStimulus(branch(32'h100, ALU_EQ, 32'd5, 32'd5, 1'b0, 32'h180));
        applyStimulus(idle(32'h100));

        // Signed vs unsigned less-than on the same operands
        applyStimulus(branch(32'h200, ALU_LT, 32'hFFFF_FFFF, 32'd1, 1'b0, 32'h280));
        applyStimulus(branch(32'h204, ALU_LTU, 32'hFFFF_FFFF, 32'd1, 1'b0, 32'h290));
        applyStimulus(idle(32'h204));

        // Saturate with four taken BNEs, then one not-taken
        for (int i = 0; i < 4; i++)
            applyStimulus(branch(32'h300, ALU_NEQ, 32'd1, 32'd2, i > 0, 32'h340));
        applyStimulus(branch(32'h300, ALU_NEQ, 32'd7, 32'd7, 1'b1, 32'h340));
        applyStimulus(idle(32'h300));

        // JALR held by a stall for two cycles, then released
        s = idle(32'h400);
        s.valid = 1'b1; s.ex_pc = 32'h400; s.jmp = 1'b1; s.target = 32'h8000; s.stall = 1'b1;
        applyStimulus(s);
        applyStimulus(s);
        s.stall = 1'b0;
        applyStimulus(s);
        applyStimulus(idle(32'h400));

        // PC+4 wraps past the top of the address space
        applyStimulus(branch(32'hFFFF_FFFC, ALU_EQ, 32'd1, 32'd2, 1'b1, 32'h10));

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            s.rst    = 1'b0;
            s.valid  = $urandom_range(0, 9) != 0;
            s.stall  = $urandom_range(0, 5) == 0;
            s.ex_pc  = ($urandom_range(0, 7) == 0) ? $urandom() : 32'h1000 + ($urandom_range(0, 15) << 2);
            s.if_pc  = $urandom_range(0, 1) ? s.ex_pc : $urandom();
            s.pred   = $urandom_range(0, 1);
            s.op     = ops[$urandom_range(0, 7)];
            s.rs1    = $urandom();
            kind     = $urandom_range(0, 3);
            s.rs2    = (kind == 0) ? $urandom() : (kind == 1) ? s.rs1 : (kind == 2) ? -s.rs1 : $urandom_range(0, 3);
            kind     = $urandom_range(0, 9);
            s.br     = (kind < 7) || (kind == 9);
            s.jmp    = (kind == 7) || (kind == 8) || (kind == 9);
            if ($urandom_range(0, 19) == 0) begin s.br = 1'b0; s.jmp = 1'b0; end
            s.target = $urandom() & 32'hFFFF_FFFC;
            applyStimulus(s);
        end

        // Mispredict, then reset asserted together with a second mispredict
        applyStimulus(branch(32'h100, ALU_EQ, 32'd3, 32'd3, 1'b0, 32'h500));
        s = branch(32'h104, ALU_EQ, 32'd3, 32'd3, 1'b0, 32'h600);
        s.rst = 1'b1;
        applyStimulus(s);
        applyStimulus(idle(32'h100));
        applyStimulus(idle(32'h300));

        @(posedge i_clk);
        #2;
        checkOutput("scoreboard_drain", exp_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
